// File: rtl/snake_body_store_pkg.sv
// rtl/snake_body_store_pkg.sv - shared grid, length and FSM constants for the snake engine
package snake_body_store_pkg;

  localparam int SNAKE_LENGTH_BIT = 7;
  localparam int SNAKE_LENGTH_MAX = 2 ** SNAKE_LENGTH_BIT;
  localparam int BODY_DEPTH       = SNAKE_LENGTH_MAX - 1;

  localparam int GRID_W = 124;
  localparam int GRID_H = 81;
  localparam int INIT_X = 10;
  localparam int INIT_Y = 40;

  typedef logic [6:0] cell_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } snake_state_t;

endpackage

// File: rtl/snake_body_store.sv
// rtl/snake_body_store.sv - snake head/body register file with move collision check and body stream
module snake_body_store
  import snake_body_store_pkg::*;
(
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        move_req,
  input  logic                        grow,
  input  logic [6:0]                  cand_x,
  input  logic [6:0]                  cand_y,
  output logic                        busy,
  output logic                        move_done,
  output logic                        wall_hit,
  output logic                        self_hit,
  output logic [6:0]                  snake_head_x,
  output logic [6:0]                  snake_head_y,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic [SNAKE_LENGTH_BIT-1:0] body_count,
  output logic [6:0]                  snake_body_x,
  output logic [6:0]                  snake_body_y
);

  localparam cell_t GRID_W_CELL = 7'(GRID_W);
  localparam cell_t GRID_H_CELL = 7'(GRID_H);
  localparam cell_t INIT_X_CELL = 7'(INIT_X);
  localparam cell_t INIT_Y_CELL = 7'(INIT_Y);
  localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_MAX  = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
  localparam logic [SNAKE_LENGTH_BIT-1:0] LAST_IDX = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 2);

  snake_state_t state, state_next;

  cell_t body_x [0:BODY_DEPTH-1];
  cell_t body_y [0:BODY_DEPTH-1];

  cell_t                       cand_lat_x;
  cell_t                       cand_lat_y;
  logic                        grow_lat;
  logic [SNAKE_LENGTH_BIT-1:0] scan_k;
  logic [SNAKE_LENGTH_BIT-1:0] scan_last;
  logic                        scan_match;
  logic                        cand_wall;
  logic                        accept;
  logic                        commit;

  assign accept    = (state == ST_IDLE) && move_req;
  assign cand_wall = (cand_x >= GRID_W_CELL) || (cand_y >= GRID_H_CELL);
  // A non-growing move may land on the tail, since the tail moves away on the same commit.
  assign scan_last  = grow_lat ? (snake_length - 7'd1) : (snake_length - 7'd2);
  assign scan_match = (body_x[scan_k] == cand_lat_x) && (body_y[scan_k] == cand_lat_y);
  assign commit     = (state == ST_DONE) && !wall_hit && !self_hit;

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    move_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (move_req) begin
          state_next = cand_wall ? ST_DONE : ST_CHECK;
        end
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (scan_match || (scan_k == scan_last)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        move_done  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      cand_lat_x <= '0;
      cand_lat_y <= '0;
      grow_lat   <= 1'b0;
      scan_k     <= '0;
      wall_hit   <= 1'b0;
      self_hit   <= 1'b0;
    end else if (accept) begin
      cand_lat_x <= cand_x;
      cand_lat_y <= cand_y;
      grow_lat   <= grow;
      scan_k     <= '0;
      wall_hit   <= cand_wall;
      self_hit   <= 1'b0;
    end else if (state == ST_CHECK) begin
      scan_k <= scan_k + 7'd1;
      if (scan_match) begin
        self_hit <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      snake_head_x <= INIT_X_CELL;
      snake_head_y <= INIT_Y_CELL;
      snake_length <= 7'd2;
    end else if (commit) begin
      snake_head_x <= cand_lat_x;
      snake_head_y <= cand_lat_y;
      if (grow_lat && (snake_length < LEN_MAX)) begin
        snake_length <= snake_length + 7'd1;
      end
    end
  end

  // Every entry moves on a commit, so the body is a shift register file rather than a RAM.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BODY_DEPTH; i++) begin
        body_x[i] <= '0;
        body_y[i] <= '0;
      end
      body_x[0] <= INIT_X_CELL - 7'd1;
      body_y[0] <= INIT_Y_CELL;
      body_x[1] <= INIT_X_CELL - 7'd2;
      body_y[1] <= INIT_Y_CELL;
    end else if (commit) begin
      body_x[0] <= snake_head_x;
      body_y[0] <= snake_head_y;
      for (int i = 1; i < BODY_DEPTH; i++) begin
        body_x[i] <= body_x[i-1];
        body_y[i] <= body_y[i-1];
      end
    end
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      body_count <= '0;
    end else if (body_count == LAST_IDX) begin
      body_count <= '0;
    end else begin
      body_count <= body_count + 7'd1;
    end
  end

  assign snake_body_x = body_x[body_count];
  assign snake_body_y = body_y[body_count];

endmodule

// File: tb/tb_snake_body_store.sv
// tb/tb_snake_body_store.sv - directed scoreboard bench for snake_body_store
module tb_snake_body_store;

  logic       clock_25 = 1'b0;
  logic       reset    = 1'b1;
  logic       move_req = 1'b0;
  logic       grow     = 1'b0;
  logic [6:0] cand_x   = '0;
  logic [6:0] cand_y   = '0;
  logic       busy, move_done, wall_hit, self_hit;
  logic [6:0] snake_head_x, snake_head_y, snake_length, body_count, snake_body_x, snake_body_y;

  snake_body_store dut (
    .clock_25     (clock_25),
    .reset        (reset),
    .move_req     (move_req),
    .grow         (grow),
    .cand_x       (cand_x),
    .cand_y       (cand_y),
    .busy         (busy),
    .move_done    (move_done),
    .wall_hit     (wall_hit),
    .self_hit     (self_hit),
    .snake_head_x (snake_head_x),
    .snake_head_y (snake_head_y),
    .snake_length (snake_length),
    .body_count   (body_count),
    .snake_body_x (snake_body_x),
    .snake_body_y (snake_body_y)
  );

  always #20 clock_25 = ~clock_25;

  typedef struct {
    logic wall;
    logic slf;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  int mx [0:126];
  int my [0:126];
  int mhx, mhy, mlen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 127; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    mx[0] = 9;  my[0] = 40;
    mx[1] = 8;  my[1] = 40;
    mhx = 10; mhy = 40; mlen = 2;
  endtask

  task automatic do_reset();
    @(negedge clock_25);
    reset = 1'b1;
    @(negedge clock_25);
    reset = 1'b0;
    model_reset();
  endtask

  // inject_at > 0 pulses a second move_req that many cycles into the operation.
  task automatic do_move(input int cx, input int cy, input logic g, input int inject_at);
    exp_t e;
    logic w, s;
    int   lim, lat, edges;
    w   = (cx >= 124) || (cy >= 81);
    s   = 1'b0;
    lim = g ? mlen : mlen - 1;
    lat = 1;
    if (!w) begin
      lat = lim + 1;
      for (int j = 0; j < lim; j++) begin
        if (mx[j] == cx && my[j] == cy) begin
          s   = 1'b1;
          lat = j + 2;
          break;
        end
      end
    end
    sb.push_back('{wall: w, slf: s, lat: lat});

    @(negedge clock_25);
    cand_x   = 7'(cx);
    cand_y   = 7'(cy);
    grow     = g;
    move_req = 1'b1;
    @(negedge clock_25);
    move_req = 1'b0;
    edges    = 1;
    while (move_done !== 1'b1 && edges < 300) begin
      if (edges == inject_at) begin
        move_req = 1'b1;
        cand_x   = 7'd0;
        cand_y   = 7'd0;
      end
      @(negedge clock_25);
      move_req = 1'b0;
      edges++;
    end
    check("move_done", move_done, 1);
    e = sb.pop_front();
    check("latency", edges, e.lat);
    check("wall_hit", wall_hit, e.wall);
    check("self_hit", self_hit, e.slf);

    @(negedge clock_25);
    if (!w && !s) begin
      for (int i = 126; i > 0; i--) begin
        mx[i] = mx[i-1];
        my[i] = my[i-1];
      end
      mx[0] = mhx; my[0] = mhy;
      mhx = cx;    mhy = cy;
      if (g && mlen < 127) mlen++;
    end
    check("head_x", snake_head_x, mhx);
    check("head_y", snake_head_y, mhy);
    check("length", snake_length, mlen);
    check("busy_idle", busy, 0);
    check("wall_held", wall_hit, e.wall);
    check("self_held", self_hit, e.slf);
  endtask

  task automatic stream_check();
    int prev, seen;
    bit hit [0:126];
    for (int i = 0; i < 127; i++) hit[i] = 1'b0;
    seen = 0;
    @(negedge clock_25);
    prev = int'(body_count) - 1;
    if (prev < 0) prev = 126;
    for (int c = 0; c < 127; c++) begin
      check("stream_count", body_count, (prev + 1) % 127);
      prev = int'(body_count);
      if (body_count < 127) begin
        check("stream_x", snake_body_x, mx[body_count]);
        check("stream_y", snake_body_y, my[body_count]);
        if (!hit[body_count]) seen++;
        hit[body_count] = 1'b1;
      end
      @(negedge clock_25);
    end
    check("stream_coverage", seen, 127);
  endtask

  task automatic path_move(input logic g);
    if (mhx < 123) do_move(mhx + 1, mhy, g, 0);
    else           do_move(mhx, mhy + 1, g, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock_25);
    check("rst_head_x", snake_head_x, 10);
    check("rst_head_y", snake_head_y, 40);
    check("rst_length", snake_length, 2);
    check("rst_body_count", body_count, 0);
    check("rst_busy", busy, 0);
    check("rst_move_done", move_done, 0);
    check("rst_wall", wall_hit, 0);
    check("rst_self", self_hit, 0);
    reset = 1'b0;

    do_move(11, 40, 1'b0, 0);
    check("body0_after_first", mx[0] * 1000 + my[0], 10040);

    do_reset();
    do_move(124, 40, 1'b0, 0);
    do_move(10, 127, 1'b0, 0);
    do_move(9, 40, 1'b0, 0);
    check("self_head_kept", snake_head_x, 10);

    do_move(8, 40, 1'b1, 0);
    do_move(8, 40, 1'b0, 0);
    check("tail_move_head", snake_head_x, 8);

    do_reset();
    for (int n = 0; n < 125; n++) path_move(1'b1);
    check("saturated_len", snake_length, 127);
    path_move(1'b1);
    check("saturated_len_hold", snake_length, 127);
    stream_check();

    path_move(1'b0);
    do_move(mhx, mhy + 1, 1'b0, 2);
    repeat (4) begin
      @(negedge clock_25);
      check("no_extra_done", move_done, 0);
      check("no_extra_busy", busy, 0);
    end

    @(negedge clock_25);
    cand_x   = 7'(mhx);
    cand_y   = 7'(mhy + 1);
    grow     = 1'b0;
    move_req = 1'b1;
    @(negedge clock_25);
    move_req = 1'b0;
    check("busy_in_check", busy, 1);
    #5 reset = 1'b1;
    #1;
    check("abort_head_x", snake_head_x, 10);
    check("abort_head_y", snake_head_y, 40);
    check("abort_length", snake_length, 2);
    check("abort_busy", busy, 0);
    check("abort_done", move_done, 0);
    @(negedge clock_25);
    check("abort_done_later", move_done, 0);
    reset = 1'b0;
    model_reset();
    do_move(11, 40, 1'b1, 0);
    stream_check();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
